card_dealer: RTL and testbench

- Downstream consumer of the free-running game counter: takes the counter value captured when the player releases reset as a seed.
- Deals blackjack cards from a tracked 52-card deck: 13 ranks, 4 copies each, suits ignored.
- Sits between the counter and the game-control FSM, which pulses a request and reads back rank and point value.

---
 rtl/card_dealer_if.sv | 25 ++
 rtl/card_dealer.sv | 107 ++++++++++
 tb/tb_card_dealer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Dealer <-> game-control bundle: seed/load/request in, dealt card and deck status out.
// Request is a level sampled in IDLE only; there is no backpressure and no queueing of requests.
interface card_dealer_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] i_Seed;
  logic             i_Load;
  logic             i_Request;
  logic [3:0]       o_Card;
  logic [3:0]       o_Points;
  logic             o_Valid;
  logic             o_Busy;
  logic [5:0]       o_CardsLeft;
  logic             o_DeckEmpty;

  modport master (
    output i_Seed, i_Load, i_Request,
    input  o_Card, o_Points, o_Valid, o_Busy, o_CardsLeft, o_DeckEmpty
  );

  modport slave (
    input  i_Seed, i_Load, i_Request,
    output o_Card, o_Points, o_Valid, o_Busy, o_CardsLeft, o_DeckEmpty
  );
endinterface

// File: rtl/card_dealer.sv
// Deals blackjack ranks from a tracked 52-card deck using a free-running 16-bit Galois LFSR.
// o_Valid follows the request edge by 3..15 edges; requests seen while o_Busy is high are dropped.
module card_dealer #(
  parameter int WIDTH  = 12,
  parameter int LFSR_W = 16
) (
  input  logic         clk_50M,
  input  logic         i_Reset,
  card_dealer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAW, PROBE, OUT} state_t;

  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 16'hACE1;

  state_t            state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [2:0]        cnt_q [13];
  logic [5:0]        left_q;
  logic [3:0]        probe_q;
  logic [3:0]        card_q;
  logic [3:0]        points_q;
  logic              valid_q;
  logic              busy_q;

  logic [WIDTH-1:0]  seed_w;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] seed_d;
  logic [3:0]        draw_d;
  logic [3:0]        probe_next_d;
  logic [3:0]        probe_idx_d;
  logic [3:0]        points_d;

  always_comb begin
    seed_w       = bus.i_Seed;
    lfsr_d       = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
    seed_d       = (seed_w == '0) ? LFSR_INIT : LFSR_W'(seed_w);
    // Low nibble folded mod 13 into 1..13: 13,14,15 wrap to 1,2,3.
    draw_d       = (lfsr_q[3:0] >= 4'd13) ? (lfsr_q[3:0] - 4'd12) : (lfsr_q[3:0] + 4'd1);
    probe_next_d = (probe_q == 4'd13) ? 4'd1 : (probe_q + 4'd1);
    probe_idx_d  = probe_q - 4'd1;
    points_d     = (probe_q >= 4'd10) ? 4'd10 : probe_q;
  end

  always_ff @(posedge clk_50M or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_INIT;
      for (int i = 0; i < 13; i++) cnt_q[i] <= 3'd4;
      left_q   <= 6'd52;
      probe_q  <= 4'd1;
      card_q   <= 4'd0;
      points_q <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_Load) begin
            lfsr_q <= seed_d;
            for (int i = 0; i < 13; i++) cnt_q[i] <= 3'd4;
            left_q <= 6'd52;
          end else if (bus.i_Request && (left_q != 6'd0)) begin
            state_q <= DRAW;
            busy_q  <= 1'b1;
          end
        end
        DRAW: begin
          probe_q <= draw_d;
          state_q <= PROBE;
        end
        PROBE: begin
          // Linear probe to the next rank still in the deck; bounded since the deck is non-empty.
          if (cnt_q[probe_idx_d] != 3'd0) begin
            cnt_q[probe_idx_d] <= cnt_q[probe_idx_d] - 3'd1;
            left_q   <= left_q - 6'd1;
            card_q   <= probe_q;
            points_q <= points_d;
            valid_q  <= 1'b1;
            state_q  <= OUT;
          end else begin
            probe_q <= probe_next_d;
          end
        end
        OUT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Card      = card_q;
  assign bus.o_Points    = points_q;
  assign bus.o_Valid     = valid_q;
  assign bus.o_Busy      = busy_q;
  assign bus.o_CardsLeft = left_q;
  assign bus.o_DeckEmpty = (left_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Directed + randomized bench for card_dealer with a deck-level reference model.
module tb_card_dealer;

  logic clk_50M = 1'b0;
  logic i_Reset = 1'b1;

  card_dealer_if #(.WIDTH(12)) bus ();

  card_dealer #(.WIDTH(12), .LFSR_W(16)) dut (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #10 clk_50M = ~clk_50M;

  int          n_chk = 0;
  int          n_err = 0;
  int          cnt_m [1:13];
  int          left_m;
  int          card_m;
  logic [15:0] lfsr_m;
  logic        ld_hon = 1'b0;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Generator state as a function of time: reset value, honoured loads, one step per edge.
  always @(posedge clk_50M or posedge i_Reset) begin
    if (i_Reset)     lfsr_m <= 16'hACE1;
    else if (ld_hon) lfsr_m <= (bus.i_Seed == 12'h000) ? 16'hACE1 : {4'h0, bus.i_Seed};
    else             lfsr_m <= galois(lfsr_m);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    @(negedge clk_50M);
  endtask

  task automatic model_fill();
    for (int r = 1; r <= 13; r++) cnt_m[r] = 4;
    left_m = 52;
  endtask

  task automatic load_seed(input logic [11:0] s);
    bus.i_Seed = s;
    bus.i_Load = 1'b1;
    ld_hon     = 1'b1;
    tick();
    bus.i_Load = 1'b0;
    ld_hon     = 1'b0;
    model_fill();
    chk("load_left", bus.o_CardsLeft, 52);
    chk("load_card_kept", bus.o_Card, card_m);
  endtask

  // One request pulse from IDLE; optional ignored load while the dealer is busy.
  task automatic deal(input bit ld_mid, output int card);
    int r, skips, lat, exp_pts;
    bit got;
    chk("idle_before_req", bus.o_Busy, 0);
    bus.i_Request = 1'b1;
    tick();
    bus.i_Request = 1'b0;
    r = int'(lfsr_m[3:0]) % 13 + 1;
    skips = 0;
    while (cnt_m[r] == 0 && skips < 13) begin
      r = (r == 13) ? 1 : r + 1;
      skips++;
    end
    if (ld_mid) begin
      chk("busy_during_deal", bus.o_Busy, 1);
      bus.i_Seed = 12'(($urandom_range(1, 4095)));
      bus.i_Load = 1'b1;
    end
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      bus.i_Load = 1'b0;
      lat++;
      if (bus.o_Valid === 1'b1) got = 1'b1;
    end
    card = bus.o_Card;
    chk("deal_valid_seen", got, 1);
    if (got) begin
      exp_pts = (r >= 10) ? 10 : r;
      chk("deal_latency", lat, 3 + skips);
      chk("deal_latency_range", (lat >= 3 && lat <= 15), 1);
      chk("deal_card", bus.o_Card, r);
      chk("deal_points", bus.o_Points, exp_pts);
      cnt_m[r]--;
      left_m--;
      card_m = r;
      chk("deal_left", bus.o_CardsLeft, left_m);
      tick();
      chk("valid_one_cycle", bus.o_Valid, 0);
    end
  endtask

  initial begin
    int c, hist [1:13], seq_a [10], seq_b [10], seq_c [10], diff;
    bit seen_v, seen_b;
    bus.i_Seed    = 12'h000;
    bus.i_Load    = 1'b0;
    bus.i_Request = 1'b0;
    model_fill();
    card_m = 0;

    // Reset state; request held while reset is asserted
    repeat (3) @(negedge clk_50M);
    chk("rst_left", bus.o_CardsLeft, 52);
    chk("rst_empty", bus.o_DeckEmpty, 0);
    chk("rst_card", bus.o_Card, 0);
    chk("rst_points", bus.o_Points, 0);
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_valid", bus.o_Valid, 0);
    bus.i_Request = 1'b1;
    seen_v = 1'b0;
    repeat (5) begin
      tick();
      if (bus.o_Valid !== 1'b0) seen_v = 1'b1;
    end
    chk("rst_req_no_valid", seen_v, 0);
    bus.i_Request = 1'b0;
    i_Reset = 1'b0;
    tick();

    // Zero seed, single deal
    load_seed(12'h000);
    deal(1'b0, c);
    chk("first_left_51", bus.o_CardsLeft, 51);

    // Exhaust the deck
    load_seed(12'h5A3);
    for (int r = 1; r <= 13; r++) hist[r] = 0;
    for (int n = 0; n < 52; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      deal(1'b0, c);
      if (c >= 1 && c <= 13) hist[c]++;
    end
    for (int r = 1; r <= 13; r++) chk("rank_hist", hist[r], 4);
    chk("exhaust_left", bus.o_CardsLeft, 0);
    chk("exhaust_empty", bus.o_DeckEmpty, 1);
    bus.i_Request = 1'b1;
    tick();
    bus.i_Request = 1'b0;
    seen_v = 1'b0;
    seen_b = 1'b0;
    repeat (6) begin
      if (bus.o_Valid !== 1'b0) seen_v = 1'b1;
      if (bus.o_Busy !== 1'b0) seen_b = 1'b1;
      tick();
    end
    chk("empty_req_no_valid", seen_v, 0);
    chk("empty_req_no_busy", seen_b, 0);

    // Determinism and seed sensitivity
    load_seed(12'h5A3);
    for (int n = 0; n < 10; n++) deal(1'b0, seq_a[n]);
    load_seed(12'h5A3);
    for (int n = 0; n < 10; n++) begin
      deal(1'b0, seq_b[n]);
      chk("same_seed_seq", seq_b[n], seq_a[n]);
    end
    load_seed(12'h001);
    diff = 0;
    for (int n = 0; n < 10; n++) begin
      deal(1'b0, seq_c[n]);
      if (seq_c[n] != seq_a[n]) diff++;
    end
    chk("other_seed_differs", (diff > 0), 1);

    // Load and request together: refill wins, no deal
    bus.i_Seed    = 12'($urandom_range(0, 4095));
    bus.i_Load    = 1'b1;
    bus.i_Request = 1'b1;
    ld_hon        = 1'b1;
    tick();
    bus.i_Load    = 1'b0;
    bus.i_Request = 1'b0;
    ld_hon        = 1'b0;
    model_fill();
    seen_v = 1'b0;
    seen_b = 1'b0;
    repeat (5) begin
      if (bus.o_Valid !== 1'b0) seen_v = 1'b1;
      if (bus.o_Busy !== 1'b0) seen_b = 1'b1;
      tick();
    end
    chk("load_req_no_valid", seen_v, 0);
    chk("load_req_no_busy", seen_b, 0);
    chk("load_req_left", bus.o_CardsLeft, 52);

    // Load while busy is ignored
    deal(1'b1, c);
    chk("busy_load_left", bus.o_CardsLeft, 51);

    // Randomized sessions
    repeat (3) begin
      load_seed(12'($urandom_range(0, 4095)));
      repeat ($urandom_range(5, 20)) begin
        repeat ($urandom_range(0, 4)) tick();
        deal(1'($urandom_range(0, 1)), c);
      end
    end

    // Reset during PROBE aborts the deal
    bus.i_Request = 1'b1;
    tick();
    bus.i_Request = 1'b0;
    tick();
    i_Reset = 1'b1;
    #1;
    chk("abort_busy", bus.o_Busy, 0);
    chk("abort_left", bus.o_CardsLeft, 52);
    chk("abort_valid", bus.o_Valid, 0);
    chk("abort_card", bus.o_Card, 0);
    seen_v = 1'b0;
    repeat (3) begin
      tick();
      if (bus.o_Valid !== 1'b0) seen_v = 1'b1;
    end
    i_Reset = 1'b0;
    model_fill();
    card_m = 0;
    tick();
    if (bus.o_Valid !== 1'b0) seen_v = 1'b1;
    chk("abort_no_valid", seen_v, 0);
    deal(1'b0, c);
    chk("after_abort_left", bus.o_CardsLeft, 51);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
